// File: rtl/led_fader.sv
// led_fader: per-LED brightness levels set by sequencer strobes, decayed by a shared prescaler, rendered by PWM.
// Optional macro LED_FADER_GAMMA_EN selects quadratic duty (level*level) over a 225-cycle PWM period.

module led_fader_lane #(
    parameter int PW = 4
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic          load,
    input  logic          dec,
    input  logic [PW-1:0] pcnt,
    output logic [3:0]    level,
    output logic          led
);
    logic [PW-1:0] duty;

    // A load beats a coincident decay; decay saturates at 0.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            level <= 4'd0;
        end else if (load) begin
            level <= 4'd15;
        end else if (dec && level != 4'd0) begin
            level <= level - 4'd1;
        end
    end

`ifdef LED_FADER_GAMMA_EN
    logic [7:0] lvl8;
    logic [7:0] sq;
    assign lvl8 = {4'd0, level};
    assign sq   = lvl8 * lvl8;
    assign duty = PW'(sq);
`else
    assign duty = PW'(level);
`endif

    // Top level reaches duty == period, so full level never drops low.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            led <= 1'b0;
        end else begin
            led <= (pcnt < duty);
        end
    end
endmodule

module led_fader #(
    parameter int N_LEDS    = 5,
    parameter int DECAY_DIV = 65536
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic [N_LEDS-1:0]   PAT_IN,
    input  logic                PAT_VALID,
    output logic [N_LEDS-1:0]   LEDS,
    output logic [4*N_LEDS-1:0] LEVELS,
    output logic                DECAY_STB
);
    localparam int DW = $clog2(DECAY_DIV);
    localparam logic [DW-1:0] DLAST = DW'(DECAY_DIV - 1);
`ifdef LED_FADER_GAMMA_EN
    localparam int PW = 8;
    localparam logic [PW-1:0] PLAST = 8'd224;
`else
    localparam int PW = 4;
    localparam logic [PW-1:0] PLAST = 4'd14;
`endif

    logic [DW-1:0] dcnt;
    logic [PW-1:0] pcnt;
    logic          dec;

    assign dec = (dcnt == DLAST);

    // Prescaler runs free of PAT_VALID so the decay cadence is fixed from reset.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            dcnt      <= '0;
            DECAY_STB <= 1'b0;
        end else begin
            dcnt      <= dec ? '0 : dcnt + 1'b1;
            DECAY_STB <= dec;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            pcnt <= '0;
        end else begin
            pcnt <= (pcnt == PLAST) ? '0 : pcnt + 1'b1;
        end
    end

    for (genvar i = 0; i < N_LEDS; i++) begin : g_lane
        led_fader_lane #(.PW(PW)) u_lane (
            .CLK   (CLK),
            .RESET (RESET),
            .load  (PAT_VALID && PAT_IN[i]),
            .dec   (dec),
            .pcnt  (pcnt),
            .level (LEVELS[4*i +: 4]),
            .led   (LEDS[i])
        );
    end
endmodule

// File: tb/tb_led_fader.sv
// Directed self-checking bench for led_fader: a DECAY_DIV=4 instance for level/decay behaviour
// and a DECAY_DIV=1024 instance for PWM duty measurement.

module tb_led_fader;
`ifdef LED_FADER_GAMMA_EN
    localparam int PER = 225;
    localparam int ON3 = 9;
`else
    localparam int PER = 15;
    localparam int ON3 = 3;
`endif

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic [4:0]  pat_in = '0;
    logic        pat_valid = 1'b0;
    logic [4:0]  leds;
    logic [19:0] levels;
    logic        stb;
    logic [4:0]  pat_in_s = '0;
    logic        pat_valid_s = 1'b0;
    logic [4:0]  leds_s;
    logic [19:0] levels_s;
    logic        stb_s;

    int errors = 0;
    int checks = 0;
    int ph = 0;

    always #5 CLK = ~CLK;

    led_fader #(.N_LEDS(5), .DECAY_DIV(4)) dut (
        .CLK(CLK), .RESET(RESET), .PAT_IN(pat_in), .PAT_VALID(pat_valid),
        .LEDS(leds), .LEVELS(levels), .DECAY_STB(stb)
    );

    led_fader #(.N_LEDS(5), .DECAY_DIV(1024)) dut_slow (
        .CLK(CLK), .RESET(RESET), .PAT_IN(pat_in_s), .PAT_VALID(pat_valid_s),
        .LEDS(leds_s), .LEVELS(levels_s), .DECAY_STB(stb_s)
    );

    // ph tracks the fast instance's dcnt during the current cycle.
    task automatic tick();
        @(posedge CLK);
        #1;
        ph = (ph + 1) % 4;
    endtask

    task automatic release_reset();
        @(posedge CLK);
        #1;
        RESET = 1'b0;
        ph = 0;
    endtask

    task automatic test_reset();
        RESET = 1'b1;
        tick();
        tick();
        checks++; if (levels !== 20'd0) begin errors++; $display("FAIL reset_levels got=%h exp=0", levels); end
        checks++; if (leds !== 5'd0) begin errors++; $display("FAIL reset_leds got=%b exp=0", leds); end
        checks++; if (stb !== 1'b0) begin errors++; $display("FAIL reset_stb got=%b exp=0", stb); end
        release_reset();
        for (int k = 1; k <= 100; k++) begin
            tick();
            checks++;
            if (stb !== ((k % 4) == 0)) begin errors++; $display("FAIL idle_stb cyc=%0d got=%b exp=%b", k, stb, (k % 4) == 0); end
            checks++;
            if (levels !== 20'd0 || leds !== 5'd0) begin errors++; $display("FAIL idle_zero cyc=%0d levels=%h leds=%b exp=0", k, levels, leds); end
        end
    endtask

    task automatic test_fade();
        int exp_l;
        int prev;
        logic d;
        pat_in = 5'b00001;
        pat_valid = 1'b1;
        tick();
        pat_valid = 1'b0;
        exp_l = 15;
        checks++; if (levels[3:0] !== 4'd15) begin errors++; $display("FAIL fade_load got=%0d exp=15", levels[3:0]); end
        for (int k = 0; k < 70; k++) begin
            prev = exp_l;
            d = (ph == 3);
            tick();
            if (d && exp_l > 0) exp_l--;
            checks++;
            if (levels[3:0] !== 4'(exp_l)) begin errors++; $display("FAIL fade_level step=%0d got=%0d exp=%0d", k, levels[3:0], exp_l); end
            checks++;
            if (levels[19:4] !== 16'd0 || leds[4:1] !== 4'd0) begin errors++; $display("FAIL fade_others step=%0d levels=%h leds=%b exp=0", k, levels, leds); end
            checks++;
            if (stb !== d) begin errors++; $display("FAIL fade_stb step=%0d got=%b exp=%b", k, stb, d); end
            if (prev == 15) begin
                checks++;
                if (leds[0] !== 1'b1) begin errors++; $display("FAIL fade_full_on step=%0d got=%b exp=1", k, leds[0]); end
            end
            if (prev == 0) begin
                checks++;
                if (leds[0] !== 1'b0) begin errors++; $display("FAIL fade_zero_off step=%0d got=%b exp=0", k, leds[0]); end
            end
        end
    endtask

    task automatic test_collision();
        int n;
        logic d;
        pat_in = 5'b11000;
        pat_valid = 1'b1;
        tick();
        pat_valid = 1'b0;
        n = 0;
        while (n < 8) begin
            d = (ph == 3);
            tick();
            if (d) n++;
        end
        checks++;
        if (levels[15:12] !== 4'd7 || levels[19:16] !== 4'd7) begin errors++; $display("FAIL coll_setup led3=%0d led4=%0d exp=7,7", levels[15:12], levels[19:16]); end
        while (ph != 3) tick();
        pat_in = 5'b10000;
        pat_valid = 1'b1;
        tick();
        pat_valid = 1'b0;
        checks++; if (levels[19:16] !== 4'd15) begin errors++; $display("FAIL coll_load_wins got=%0d exp=15", levels[19:16]); end
        checks++; if (levels[15:12] !== 4'd6) begin errors++; $display("FAIL coll_clear_decays got=%0d exp=6", levels[15:12]); end
        checks++; if (stb !== 1'b1) begin errors++; $display("FAIL coll_stb got=%b exp=1", stb); end
    endtask

    task automatic test_back_to_back();
        while (ph != 0) tick();
        pat_in = 5'b00010;
        pat_valid = 1'b1;
        tick();
        checks++; if (levels[7:4] !== 4'd15) begin errors++; $display("FAIL b2b_first got=%0d exp=15", levels[7:4]); end
        pat_in = 5'b00001;
        tick();
        pat_valid = 1'b0;
        checks++;
        if (levels[7:4] !== 4'd15 || levels[3:0] !== 4'd15) begin errors++; $display("FAIL b2b_second led1=%0d led0=%0d exp=15,15", levels[7:4], levels[3:0]); end
    endtask

    task automatic test_reset_mid();
        int n;
        logic d;
        pat_in = 5'b00100;
        pat_valid = 1'b1;
        tick();
        pat_valid = 1'b0;
        n = 0;
        while (n < 6) begin
            d = (ph == 3);
            tick();
            if (d) n++;
        end
        checks++; if (levels[11:8] !== 4'd9) begin errors++; $display("FAIL mid_setup got=%0d exp=9", levels[11:8]); end
        checks++; if (stb !== 1'b1) begin errors++; $display("FAIL mid_pre_stb got=%b exp=1", stb); end
        #2;
        RESET = 1'b1;
        #1;
        checks++; if (levels !== 20'd0) begin errors++; $display("FAIL mid_levels got=%h exp=0", levels); end
        checks++; if (leds !== 5'd0) begin errors++; $display("FAIL mid_leds got=%b exp=0", leds); end
        checks++; if (stb !== 1'b0) begin errors++; $display("FAIL mid_stb got=%b exp=0", stb); end
        tick();
        tick();
        release_reset();
        for (int k = 1; k <= 8; k++) begin
            tick();
            checks++;
            if (stb !== ((k % 4) == 0)) begin errors++; $display("FAIL mid_phase cyc=%0d got=%b exp=%b", k, stb, (k % 4) == 0); end
        end
    endtask

    task automatic test_pwm();
        int cnt;
        int t;
        cnt = 0;
        for (int k = 0; k < PER; k++) begin tick(); cnt += int'(leds_s[0]); end
        checks++; if (cnt !== 0) begin errors++; $display("FAIL pwm_level0 on=%0d exp=0", cnt); end
        pat_in_s = 5'b00001;
        pat_valid_s = 1'b1;
        tick();
        pat_valid_s = 1'b0;
        tick();
        cnt = 0;
        for (int k = 0; k < PER; k++) begin tick(); cnt += int'(leds_s[0]); end
        checks++; if (cnt !== PER) begin errors++; $display("FAIL pwm_level15 on=%0d exp=%0d", cnt, PER); end
        t = 0;
        while (levels_s[3:0] !== 4'd3 && t < 20000) begin tick(); t++; end
        checks++;
        if (t >= 20000) begin errors++; $display("FAIL pwm_wait_level3 timeout level=%0d exp=3", levels_s[3:0]); end
        tick();
        tick();
        cnt = 0;
        for (int k = 0; k < PER; k++) begin tick(); cnt += int'(leds_s[0]); end
        checks++; if (cnt !== ON3) begin errors++; $display("FAIL pwm_level3 on=%0d exp=%0d", cnt, ON3); end
        checks++; if (levels_s[3:0] !== 4'd3) begin errors++; $display("FAIL pwm_level3_hold got=%0d exp=3", levels_s[3:0]); end
        checks++; if (leds_s[4:1] !== 4'd0) begin errors++; $display("FAIL pwm_others got=%b exp=0", leds_s[4:1]); end
    endtask

    initial begin
        test_reset();
        test_fade();
        test_collision();
        test_back_to_back();
        test_reset_mid();
        test_pwm();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
